usb_tr_sipo_demux: RTL and testbench
====================================

# usb_tr_sipo_demux

Receive-side counterpart of the PISO→USB_TR transmit mux. It takes the single serial bit stream delivered by the USB_TR receiver and strips a per-packet device-select header. It then routes the remaining payload bits, with valid/last framing, to exactly one of NUMBER_OF_SIPO serial-in/parallel-out deserializers. Packets aimed at a non-ready or nonexistent SIPO are dropped and flagged.

## Interface
- NUMBER_OF_SIPO, 1: number of downstream SIPO deserializers (1..16).
- SEL_WIDTH, 4: header width in bits; 2^SEL_WIDTH >= NUMBER_OF_SIPO.
- clk  in  1  block clock; all logic on rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- usb_tr_rx_data  in  1  serial bit from USB_TR.
- usb_tr_rx_data_val  in  1  usb_tr_rx_data valid this cycle.
- usb_tr_rx_data_last  in  1  qualifies the final bit of a packet (only with val).
- sipo_ready  in  NUMBER_OF_SIPO  SIPO i can accept a new packet.
- sipo_data_in  out  NUMBER_OF_SIPO  serial payload bit to SIPO i.
- sipo_data_val  out  NUMBER_OF_SIPO  bit valid to SIPO i (one-hot or zero).
- sipo_data_last  out  NUMBER_OF_SIPO  last payload bit to SIPO i.
- usb_tr_rx_busy  out  1  packet in progress (state != IDLE).
- usb_tr_rx_drop  out  1  one-cycle pulse when a packet is dropped.

## Operation
- States: IDLE, HDR, FWD, DROP. All outputs are registered.
- IDLE: the first valid bit is header bit 0 (LSB first); shift it into sel_shift, bit counter = 1, go to HDR. If that bit carries last, it is a runt: pulse drop, stay IDLE.
- HDR: each valid bit shifts into sel_shift. After SEL_WIDTH header bits, latch current_device = header value.
  - If current_device >= NUMBER_OF_SIPO, or sipo_ready[current_device] == 0 (sampled in the cycle the final header bit arrives), go to DROP.
  - Otherwise go to FWD.
- HDR, last on any header bit (including the final one): runt. Pulse drop, return to IDLE; no SIPO output.
- FWD: each valid bit drives sipo_data_in/val[current_device] = bit/1 one cycle later. Last is forwarded on sipo_data_last[current_device]; state returns to IDLE.
- DROP: consume bits silently until the bit with last, then pulse usb_tr_rx_drop and return to IDLE.
- Cycles with val = 0 are gaps. State, counter and outputs hold, except sipo_data_val/last, which are 0.
- Non-selected SIPO lanes: data/val/last = 0 at all times.
- sipo_ready is not rechecked after the header; a SIPO that drops ready mid-packet still receives the whole packet.

## Timing
- Reset (async assert, sync release): state = IDLE, sel_shift = 0, counter = 0, current_device = 0. All sipo_* outputs = 0, busy = 0, drop = 0 (and drop count = 0 when enabled).
- Latency: input bit at cycle n → SIPO output at cycle n+1.
- Back-to-back packets: a new header bit may arrive in the cycle immediately after the last bit of the previous packet. IDLE accepts it without a bubble, because the FWD→IDLE transition happens on that same edge.
- Drop pulse: asserted the cycle after the terminating last bit (runt or DROP exit), for one cycle.
- Reset mid-packet: the packet is abandoned without a drop pulse; the next valid bit after release is a header bit.
- Header counter wraps only via its return to IDLE; it never exceeds SEL_WIDTH.

## Configuration
- USB_DEMUX_DROP_CNT_EN defined: adds output usb_tr_rx_drop_cnt [7:0], an 8-bit saturating count of drop pulses (stays at 255). It resets to 0 and is incremented in the same cycle the drop pulse is asserted.
- Not defined: no port, no counter logic; drop pulse behaviour unchanged.

## Test plan
- NUMBER_OF_SIPO=4, SEL_WIDTH=4, sipo_ready=4'b1111. Send header 4'd2 (LSB first) + payload 1,0,1,1 (last on the final bit) → sipo_data_val[2] high for 4 cycles, data 1,0,1,1, last on the 4th, each one cycle after its input; lanes 0,1,3 stay 0; no drop.
- Header 4'd5 with 8 payload bits → no SIPO activity; drop pulses once, one cycle after last; drop_cnt = 1 if enabled.
- sipo_ready[1] = 0, header 4'd1 → packet dropped. Raise ready and resend → delivered.
- Last on header bit 2 (runt) → drop pulse; the next packet is decoded correctly.
- Gaps: payload with val = 0 cycles interleaved → output bits identical, val low during gaps. Back-to-back packet to SIPO 3 right after last → delivered without a bubble.
- Assert rst_n low mid-FWD → all outputs 0 immediately. After release, header 4'd0 + 2 bits → delivered to SIPO 0. With macro, 300 drops → drop_cnt = 255.

Source files
------------

// File: rtl/usb_tr_sipo_demux.sv
// usb_tr_sipo_demux: strips an LSB-first device-select header and routes the serial payload to one SIPO lane.
// Optional USB_DEMUX_DROP_CNT_EN adds an 8-bit saturating count of dropped packets.
module usb_tr_sipo_demux #(
  parameter int NUMBER_OF_SIPO = 1,
  parameter int SEL_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      usb_tr_rx_data,
  input  logic                      usb_tr_rx_data_val,
  input  logic                      usb_tr_rx_data_last,
  input  logic [NUMBER_OF_SIPO-1:0] sipo_ready,
  output logic [NUMBER_OF_SIPO-1:0] sipo_data_in,
  output logic [NUMBER_OF_SIPO-1:0] sipo_data_val,
  output logic [NUMBER_OF_SIPO-1:0] sipo_data_last,
  output logic                      usb_tr_rx_busy,
`ifdef USB_DEMUX_DROP_CNT_EN
  output logic [7:0]                usb_tr_rx_drop_cnt,
`endif
  output logic                      usb_tr_rx_drop
);
  localparam int CW = $clog2(SEL_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;
  state_t                    r_state;
  logic [SEL_WIDTH-1:0]      r_sel_shift;
  logic [SEL_WIDTH-1:0]      r_dev;
  logic [CW-1:0]             r_cnt;
  logic [SEL_WIDTH:0]        w_shift_src;
  logic [SEL_WIDTH-1:0]      w_sel_nxt;
  logic [CW-1:0]             w_cnt_nxt;
  logic                      w_hdr_done;
  logic                      w_drop_evt;
  logic [NUMBER_OF_SIPO-1:0] w_hdr_lane;
  logic [NUMBER_OF_SIPO-1:0] w_lane;
  always_comb begin
    w_shift_src = {usb_tr_rx_data, (r_state == IDLE) ? {SEL_WIDTH{1'b0}} : r_sel_shift};
    w_sel_nxt   = w_shift_src[SEL_WIDTH:1];
    w_cnt_nxt   = (r_state == IDLE) ? CW'(1) : r_cnt + 1'b1;
    w_hdr_done  = w_cnt_nxt == CW'(SEL_WIDTH);
    w_drop_evt  = usb_tr_rx_data_val && usb_tr_rx_data_last && (r_state != FWD);
    // Out-of-range selects shift the one-hot off the end, so they read as "not ready".
    w_hdr_lane  = NUMBER_OF_SIPO'(1) << w_sel_nxt;
    w_lane      = NUMBER_OF_SIPO'(1) << r_dev;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_sel_shift    <= '0;
      r_dev          <= '0;
      r_cnt          <= '0;
      sipo_data_in   <= '0;
      sipo_data_val  <= '0;
      sipo_data_last <= '0;
      usb_tr_rx_busy <= 1'b0;
      usb_tr_rx_drop <= 1'b0;
    end else begin
      sipo_data_val  <= '0;
      sipo_data_last <= '0;
      usb_tr_rx_drop <= w_drop_evt;
      if (usb_tr_rx_data_val) begin
        case (r_state)
          IDLE, HDR: begin
            r_sel_shift <= w_sel_nxt;
            if (usb_tr_rx_data_last) begin
              r_state        <= IDLE;
              r_cnt          <= '0;
              usb_tr_rx_busy <= 1'b0;
            end else if (w_hdr_done) begin
              r_dev          <= w_sel_nxt;
              r_cnt          <= w_cnt_nxt;
              sipo_data_in   <= '0;
              r_state        <= |(sipo_ready & w_hdr_lane) ? FWD : DROP;
              usb_tr_rx_busy <= 1'b1;
            end else begin
              r_cnt          <= w_cnt_nxt;
              r_state        <= HDR;
              usb_tr_rx_busy <= 1'b1;
            end
          end
          FWD: begin
            sipo_data_in   <= usb_tr_rx_data ? w_lane : '0;
            sipo_data_val  <= w_lane;
            sipo_data_last <= usb_tr_rx_data_last ? w_lane : '0;
            r_state        <= usb_tr_rx_data_last ? IDLE : FWD;
            r_cnt          <= usb_tr_rx_data_last ? '0 : r_cnt;
            usb_tr_rx_busy <= !usb_tr_rx_data_last;
          end
          default: begin
            r_state        <= usb_tr_rx_data_last ? IDLE : DROP;
            r_cnt          <= usb_tr_rx_data_last ? '0 : r_cnt;
            usb_tr_rx_busy <= !usb_tr_rx_data_last;
          end
        endcase
      end
    end
  end
`ifdef USB_DEMUX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) usb_tr_rx_drop_cnt <= '0;
    else if (w_drop_evt && usb_tr_rx_drop_cnt != 8'hFF) usb_tr_rx_drop_cnt <= usb_tr_rx_drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_usb_tr_sipo_demux.sv
// tb_usb_tr_sipo_demux: directed and randomized packets checked against a per-packet bit-index model.
module tb_usb_tr_sipo_demux;
  localparam int N  = 4;
  localparam int SW = 4;
  logic clk = 1'b0, rst_n = 1'b0, d = 1'b0, v = 1'b0, l = 1'b0;
  logic [N-1:0] rdy = '1;
  logic [N-1:0] sd, sv, sl;
  logic busy, drop;
`ifdef USB_DEMUX_DROP_CNT_EN
  logic [7:0] dcnt;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  usb_tr_sipo_demux #(.NUMBER_OF_SIPO(N), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .usb_tr_rx_data(d), .usb_tr_rx_data_val(v), .usb_tr_rx_data_last(l),
    .sipo_ready(rdy),
    .sipo_data_in(sd), .sipo_data_val(sv), .sipo_data_last(sl),
    .usb_tr_rx_busy(busy),
`ifdef USB_DEMUX_DROP_CNT_EN
    .usb_tr_rx_drop_cnt(dcnt),
`endif
    .usb_tr_rx_drop(drop)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: k = bits seen in the current packet; the first SW bits form the header.
  int k, hdr, dev, e_cnt, drops_seen;
  bit ok;
  logic [N-1:0] e_d, e_v, e_l;
  logic e_busy, e_drop;
  int lane_n[N];
  logic [63:0] lane_bits[N];

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0; hdr = 0; dev = 0; ok = 0; e_cnt = 0;
      e_d = '0; e_v = '0; e_l = '0; e_drop = 1'b0;
    end else begin
      e_v = '0; e_l = '0; e_drop = 1'b0;
      if (v) begin
        if (k < SW) begin
          hdr = hdr + (int'(d) << k);
          k++;
          if (l) begin
            e_drop = 1'b1; k = 0; hdr = 0;
          end else if (k == SW) begin
            dev = hdr;
            ok = (dev < N) && (rdy[dev] === 1'b1);
            e_d = '0;
          end
        end else begin
          if (ok) begin
            e_d = N'(d) << dev; e_v = N'(1) << dev; e_l = N'(l) << dev;
          end else if (l) e_drop = 1'b1;
          if (l) begin k = 0; hdr = 0; end
        end
      end
      if (e_drop && e_cnt < 255) e_cnt++;
    end
    e_busy = k != 0;
    #1;
    chk("data_in", 32'(sd), 32'(e_d));
    chk("data_val", 32'(sv), 32'(e_v));
    chk("data_last", 32'(sl), 32'(e_l));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("drop", 32'(drop), 32'(e_drop));
`ifdef USB_DEMUX_DROP_CNT_EN
    chk("drop_cnt", 32'(dcnt), 32'(e_cnt));
`endif
    for (int i = 0; i < N; i++)
      if (sv[i] === 1'b1) begin
        lane_n[i]++;
        lane_bits[i] = {lane_bits[i][62:0], sd[i]};
      end
    if (drop === 1'b1) drops_seen++;
  end

  task automatic drv(input logic vv, input logic dd, input logic ll);
    @(negedge clk);
    v = vv; d = dd; l = ll;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pkt(input int h, input int len, input logic [63:0] pl, input int gap);
    for (int i = 0; i < SW; i++) begin
      if (gap > 0 && $urandom_range(0, gap) == 0) drv(1'b0, 1'b0, 1'b0);
      drv(1'b1, h[i], 1'b0);
    end
    for (int i = 0; i < len; i++) begin
      if (gap > 0 && $urandom_range(0, gap) == 0) drv(1'b0, 1'b0, 1'b0);
      if (gap > 0 && $urandom_range(0, 5) == 0) rdy = ~rdy;
      drv(1'b1, pl[i], i == len - 1);
    end
  endtask

  task automatic runt(input int h, input int r);
    for (int i = 0; i <= r; i++) drv(1'b1, h[i], i == r);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin lane_n[i] = 0; lane_bits[i] = '0; end
    drops_seen = 0;
    idle(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop), 0);
    chk("rst_val", 32'(sv), 0);
    rst_n = 1'b1;
    pkt(2, 4, 64'b1101, 0);
    idle(2);
    chk("t1_count", lane_n[2], 4);
    chk("t1_bits", 32'(lane_bits[2][3:0]), 32'b1011);
    chk("t1_other_lanes", lane_n[0] + lane_n[1] + lane_n[3], 0);
    chk("t1_drops", drops_seen, 0);
    pkt(5, 8, 64'hA5, 0);
    idle(2);
    chk("t2_drops", drops_seen, 1);
    chk("t2_no_output", lane_n[0] + lane_n[1] + lane_n[2] + lane_n[3], 4);
    rdy = 4'b1101;
    pkt(1, 3, 64'b101, 0);
    idle(2);
    chk("t3_drops", drops_seen, 2);
    chk("t3_lane1_none", lane_n[1], 0);
    rdy = '1;
    pkt(1, 3, 64'b101, 0);
    idle(2);
    chk("t3_lane1_count", lane_n[1], 3);
    chk("t3_lane1_bits", 32'(lane_bits[1][2:0]), 32'b101);
    runt(6, 2);
    pkt(0, 2, 64'b10, 0);
    idle(2);
    chk("t4_drops", drops_seen, 3);
    chk("t4_lane0_count", lane_n[0], 2);
    chk("t4_lane0_bits", 32'(lane_bits[0][1:0]), 32'b01);
    pkt(3, 6, 64'b101101, 2);
    rdy = '1;
    pkt(3, 2, 64'b11, 0);
    idle(2);
    chk("t5_lane3_count", lane_n[3], 8);
    chk("t5_lane3_bits", 32'(lane_bits[3][7:0]), 32'b10110111);
    for (int i = 0; i < SW; i++) drv(1'b1, (i == 1), 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    drv(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0; v = 1'b0;
    #1;
    chk("t6_async_val", 32'(sv), 0);
    chk("t6_async_data", 32'(sd), 0);
    chk("t6_async_busy", 32'(busy), 0);
    idle(2);
    rst_n = 1'b1;
    pkt(0, 2, 64'b11, 0);
    idle(2);
    chk("t6_lane0_count", lane_n[0], 4);
    chk("t6_no_drop", drops_seen, 3);
    for (int p = 0; p < 150; p++) begin
      int h;
      if ($urandom_range(0, 3) == 0) rdy = N'($urandom_range(0, 15));
      h = $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) runt(h, $urandom_range(0, SW - 1));
      else pkt(h, $urandom_range(1, 8), {$urandom, $urandom}, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
`ifdef USB_DEMUX_DROP_CNT_EN
    repeat (300) drv(1'b1, 1'b0, 1'b1);
    idle(2);
    chk("t7_sat_cnt", 32'(dcnt), 255);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
